pixel_stream_gen: RTL
=====================

PIXEL_STREAM_GEN -- requirements
Module: pixel_stream_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, meaning active pixels per line.
REQ-002 SHALL have parameter H_PULSE, default 41, meaning H_sync low width in clocks.
REQ-003 SHALL have parameter H_BP, default 2, meaning horizontal back porch in clocks.
REQ-004 SHALL have parameter H_FP, default 2, meaning horizontal front porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 272, meaning active lines per frame.
REQ-006 SHALL have parameters V_PULSE, V_BP and V_FP, defaults 10, 2 and 2, meaning the vertical sync width, back porch and front porch in lines.
REQ-007 SHALL have port CLK, input, 1 bit, meaning the single pixel clock; all logic is on its rising edge.
REQ-008 SHALL have port RST, input, 1 bit, meaning the reset, which is synchronous and active-high.
REQ-009 SHALL have port RUN, input, 1 bit, meaning a level request to generate frames.
REQ-010 SHALL have port Pattern_sel, input, 2 bits: 00 solid, 01 colour bars, 10 gradient, 11 checkerboard.
REQ-011 SHALL have port SOLID_color, input, 16 bits, meaning the RGB565 colour for pattern 00.
REQ-012 SHALL have port EN_out, output, 1 bit, meaning an active-pixel qualifier.
REQ-013 SHALL have port H_sync_out, output, 1 bit, meaning horizontal sync, active-low.
REQ-014 SHALL have port V_sync_out, output, 1 bit, meaning vertical sync, active-low.
REQ-015 SHALL have port DATA_out, output, 16 bits, meaning RGB565 pixel data {R[4:0],G[5:0],B[4:0]}.
REQ-016 SHALL have port Frame_start, output, 1 bit, meaning a one-clock pulse at the first clock of each frame.
REQ-017 SHALL have port Frame_cnt, output, 8 bits, meaning the number of frames started, modulo 256.

Function
REQ-018 SHALL define H_TOTAL as H_PULSE+H_BP+H_ACTIVE+H_FP (525 at defaults) and V_TOTAL as V_PULSE+V_BP+V_ACTIVE+V_FP (286 at defaults).
REQ-019 SHALL implement a two-state FSM with states IDLE and ACTIVE.
REQ-020 SHALL hold h_cnt=0 and v_cnt=0 in IDLE, go to ACTIVE on the first clock with RUN=1, and emit the frame's first pixel clock (h_cnt=0, v_cnt=0) on the next clock.
REQ-021 SHALL, in ACTIVE, increment h_cnt each clock, wrap h_cnt from H_TOTAL-1 to 0 and increment v_cnt on that wrap, and wrap v_cnt from V_TOTAL-1 to 0.
REQ-022 SHALL sample RUN only at the last clock of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1); with RUN=0 it returns to IDLE, so frames are never truncated.
REQ-023 SHALL order each line as sync (h_cnt 0..H_PULSE-1), back porch, active, front porch, and order each frame's lines the same way using v_cnt.
REQ-024 SHALL register every output with a fixed latency of 1 clock from the counter state it encodes; EN_out, the syncs and DATA_out are mutually aligned.
REQ-025 SHALL drive H_sync_out=0 while h_cnt<H_PULSE and 1 otherwise, in ACTIVE.
REQ-026 SHALL drive V_sync_out=0 while v_cnt<V_PULSE and 1 otherwise, in ACTIVE.
REQ-027 SHALL drive EN_out=1 only when both x=h_cnt-(H_PULSE+H_BP) lies in 0..H_ACTIVE-1 and y=v_cnt-(V_PULSE+V_BP) lies in 0..V_ACTIVE-1.
REQ-028 SHALL drive DATA_out=0 whenever EN_out=0.
REQ-029 SHALL latch Pattern_sel and SOLID_color only at h_cnt=0, v_cnt=0, so that a change mid-frame takes effect at the next frame.
REQ-030 SHALL, for pattern 00, output the latched SOLID_color.
REQ-031 SHALL, for pattern 01, output 8 bars of width H_ACTIVE/8, with the last bar absorbing any remainder, in the order white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
REQ-032 SHALL, for pattern 10, output R=x[8:4], G=x[8:3] and B=31-x[8:4], truncated to field width.
REQ-033 SHALL, for pattern 11, output FFFF when x[4]^y[4]^Frame_cnt[0]=0 and 0000 otherwise.
REQ-034 SHALL pulse Frame_start with the output cycle of h_cnt=0, v_cnt=0.
REQ-035 SHALL increment Frame_cnt in the same clock as Frame_start, wrapping from 255 to 0.
REQ-036 SHALL, in IDLE, drive EN_out=0, H_sync_out=1, V_sync_out=1, DATA_out=0 and Frame_start=0.

Reset
REQ-037 SHALL, when RST=1 at a clock edge, enter IDLE, clear h_cnt, v_cnt, Frame_cnt and the latched pattern/colour, and set the outputs to EN_out=0, H_sync_out=1, V_sync_out=1, DATA_out=0, Frame_start=0.
REQ-038 SHALL have RST take priority over RUN, including mid-frame; after RST is released and RUN=1, the next frame starts from h_cnt=0, v_cnt=0.

Verification
REQ-039 SHALL cover: RST=1 then RUN=1 held -> Frame_start is high 2 clocks after the first RUN=1 clock, H_sync_out is low for 41 clocks every 525 clocks, and V_sync_out is low for 10 lines (5250 clocks).
REQ-040 SHALL cover: one full default frame -> exactly 480x272=130560 clocks with EN_out=1, each line's active run contiguous, first active pixel 43 clocks after the H_sync falling edge.
REQ-041 SHALL cover: Pattern_sel=01 -> DATA_out is FFFF for x=0..59, FFE0 for x=60..119, and 0000 for x=420..479.
REQ-042 SHALL cover: Pattern_sel changed 00->10 mid-frame with SOLID_color=F800 -> the rest of the frame stays F800, and in the next frame x=479 gives DATA_out={5'd29,6'd59,5'd2}.
REQ-043 SHALL cover: RUN dropped mid-frame -> the frame completes all 286 lines, then the block enters IDLE with the syncs high; Frame_cnt wraps 255->0 after 256 frames.
REQ-044 SHALL cover: RST asserted mid-line -> the outputs take their reset values at the next clock, and Frame_cnt=0.

Source files
------------

// File: rtl/pixel_stream_gen_if.sv
// Video stream bundle produced by pixel_stream_gen: qualifier, syncs, RGB565 data and frame markers.
interface pixel_stream_gen_if;
    logic        EN_out;
    logic        H_sync_out;
    logic        V_sync_out;
    logic [15:0] DATA_out;
    logic        Frame_start;
    logic [7:0]  Frame_cnt;

    modport master (
        output EN_out, H_sync_out, V_sync_out, DATA_out, Frame_start, Frame_cnt
    );

    modport slave (
        input EN_out, H_sync_out, V_sync_out, DATA_out, Frame_start, Frame_cnt
    );
endinterface

// File: rtl/pixel_stream_gen.sv
// Raster timing generator with built-in RGB565 test patterns; all outputs registered one clock
// behind the h/v counter state they describe.
//
// state  | meaning
// IDLE   | counters held at 0, outputs parked (syncs high, no data)
// ACTIVE | scanning; RUN is only re-checked on the last clock of a frame
module pixel_stream_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_PULSE  = 41,
    parameter int H_BP     = 2,
    parameter int H_FP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_PULSE  = 10,
    parameter int V_BP     = 2,
    parameter int V_FP     = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RUN,
    input  logic [1:0]         Pattern_sel,
    input  logic [15:0]        SOLID_color,
    pixel_stream_gen_if.master vid
);

    localparam int H_TOTAL = H_PULSE + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_PULSE + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // Pattern maths reads x[8:3] and y[4], so keep at least that many bits.
    localparam int XW      = (HW > 9) ? HW : 9;
    localparam int YW      = (VW > 5) ? VW : 5;
    localparam int H_START = H_PULSE + H_BP;
    localparam int V_START = V_PULSE + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic          h_last, v_last, frame_first;

    logic [1:0]    pat_q;
    logic [15:0]   solid_q;

    logic [XW-1:0] x_pix;
    logic [YW-1:0] y_pix;
    logic          h_act, v_act, en_c;
    logic [2:0]    bar_idx;
    logic [15:0]   bar_color, pix_c;

    logic          en_q, hs_q, vs_q, fs_q;
    logic [15:0]   data_q;
    logic [7:0]    fc_q;

    assign h_last      = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last      = (v_cnt == VW'(V_TOTAL - 1));
    assign frame_first = (state == ACTIVE) && (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        h_nxt     = '0;
        v_nxt     = '0;
        case (state)
            IDLE: begin
                if (RUN) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (h_last) begin
                    if (v_last) begin
                        if (!RUN) state_nxt = IDLE;
                    end else begin
                        v_nxt = v_cnt + VW'(1);
                    end
                end else begin
                    h_nxt = h_cnt + HW'(1);
                    v_nxt = v_cnt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pattern controls are frozen per frame so a mid-frame change never tears the image.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pat_q   <= 2'b00;
            solid_q <= 16'h0000;
        end else if (frame_first) begin
            pat_q   <= Pattern_sel;
            solid_q <= SOLID_color;
        end
    end

    assign x_pix = XW'(h_cnt) - XW'(H_START);
    assign y_pix = YW'(v_cnt) - YW'(V_START);
    assign h_act = (h_cnt >= HW'(H_START)) && (x_pix < XW'(H_ACTIVE));
    assign v_act = (v_cnt >= VW'(V_START)) && (y_pix < YW'(V_ACTIVE));
    assign en_c  = (state == ACTIVE) && h_act && v_act;

    // Bar 7 has no upper bound, so it soaks up the H_ACTIVE % 8 leftover pixels.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(x_pix) >= k * BAR_W) bar_idx = 3'(k);
        end
    end

    always_comb begin
        bar_color = 16'h0000;
        case (bar_idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    end

    always_comb begin
        pix_c = 16'h0000;
        case (pat_q)
            2'b00:   pix_c = solid_q;
            2'b01:   pix_c = bar_color;
            2'b10:   pix_c = {x_pix[8:4], x_pix[8:3], 5'd31 - x_pix[8:4]};
            default: pix_c = (x_pix[4] ^ y_pix[4] ^ fc_q[0]) ? 16'h0000 : 16'hFFFF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            en_q   <= 1'b0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            data_q <= 16'h0000;
            fs_q   <= 1'b0;
            fc_q   <= 8'd0;
        end else begin
            en_q   <= en_c;
            hs_q   <= !((state == ACTIVE) && (h_cnt < HW'(H_PULSE)));
            vs_q   <= !((state == ACTIVE) && (v_cnt < VW'(V_PULSE)));
            data_q <= en_c ? pix_c : 16'h0000;
            fs_q   <= frame_first;
            if (frame_first) fc_q <= fc_q + 8'd1;
        end
    end

    assign vid.EN_out      = en_q;
    assign vid.H_sync_out  = hs_q;
    assign vid.V_sync_out  = vs_q;
    assign vid.DATA_out    = data_q;
    assign vid.Frame_start = fs_q;
    assign vid.Frame_cnt   = fc_q;

endmodule
